// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding memory request, registered output buffer towards the decoder.
// Define FETCH_BUF2_EN for a 2-entry output FIFO; the default build uses a 1-entry buffer.
module fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              id_ready,
    output logic              if_valid,
    output logic [31:0]       if_instr,
    output logic [ADDR_W-1:0] if_pc
);

`ifdef FETCH_BUF2_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_HOLD,
        S_DISCARD
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next;

    // Buffer entry 0 is the head and drives the decoder outputs directly.
    logic [1:0]        count;
    logic [1:0]        count_after;
    logic [31:0]       instr0;
    logic [ADDR_W-1:0] pc0;
`ifdef FETCH_BUF2_EN
    logic [31:0]       instr1;
    logic [ADDR_W-1:0] pc1;
`endif

    logic pop;
    logic push;
    logic free_after;
    logic unused_redirect_bits;

    assign unused_redirect_bits = ^redirect_pc[1:0];

    assign pop        = (count != 2'd0) && id_ready;
    assign push       = (state == S_WAIT) && imem_rvalid && !redirect_valid;
    assign count_after = count - {1'b0, pop} + {1'b0, push};
    assign free_after = (count_after < 2'(DEPTH));

    assign imem_req  = (state == S_FETCH);
    assign imem_addr = pc;
    assign if_valid  = (count != 2'd0);
    assign if_instr  = instr0;
    assign if_pc     = pc0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    // A redirect that meets an in-flight response in the same cycle retires that response
    // immediately, so no DISCARD is needed (otherwise DISCARD would wait forever).
    always_comb begin
        state_next = state;
        pc_next    = pc;
        case (state)
            S_FETCH: begin
                if (imem_gnt) state_next = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    pc_next    = pc + ADDR_W'(4);
                    state_next = free_after ? S_FETCH : S_HOLD;
                end
            end
            S_HOLD: begin
                if (pop) state_next = S_FETCH;
            end
            S_DISCARD: begin
                if (imem_rvalid) state_next = S_FETCH;
            end
            default: state_next = S_FETCH;
        endcase

        if (redirect_valid) begin
            pc_next = {redirect_pc[ADDR_W-1:2], 2'b00};
            case (state)
                S_FETCH:   state_next = imem_gnt ? S_DISCARD : S_FETCH;
                S_HOLD:    state_next = S_FETCH;
                S_WAIT:    state_next = imem_rvalid ? S_FETCH : S_DISCARD;
                S_DISCARD: state_next = imem_rvalid ? S_FETCH : S_DISCARD;
                default:   state_next = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= 2'd0;
            instr0 <= '0;
            pc0    <= '0;
`ifdef FETCH_BUF2_EN
            instr1 <= '0;
            pc1    <= '0;
`endif
        end else if (redirect_valid) begin
            count <= 2'd0;
        end else begin
            count <= count_after;
`ifdef FETCH_BUF2_EN
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        instr0 <= imem_rdata;
                        pc0    <= pc;
                    end else begin
                        instr1 <= imem_rdata;
                        pc1    <= pc;
                    end
                end
                2'b01: begin
                    instr0 <= instr1;
                    pc0    <= pc1;
                end
                2'b11: begin
                    if (count == 2'd2) begin
                        instr0 <= instr1;
                        pc0    <= pc1;
                        instr1 <= imem_rdata;
                        pc1    <= pc;
                    end else begin
                        instr0 <= imem_rdata;
                        pc0    <= pc;
                    end
                end
                default: ;
            endcase
`else
            if (push) begin
                instr0 <= imem_rdata;
                pc0    <= pc;
            end
`endif
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory model with configurable latency and a scoreboard of expected fetches.
module tb_fetch_unit;

    localparam int ADDR_W = 32;
`ifdef FETCH_BUF2_EN
    localparam int BUF_DEPTH = 2;
`else
    localparam int BUF_DEPTH = 1;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [31:0]       imem_rdata;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              id_ready;
    logic              if_valid;
    logic [31:0]       if_instr;
    logic [ADDR_W-1:0] if_pc;

    always #5 clk = ~clk;

    fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_ready(id_ready), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        expq[$];
    int          checkCount = 0;
    int          passCount  = 0;
    int          memLat     = 1;
    bit          memPend    = 1'b0;
    int          memCnt     = 0;
    logic [31:0] memAddr    = '0;
    bit          lastGnt    = 1'b0;
    logic [31:0] lastGntAddr = '0;
    int          rvalidCount = 0;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got === exp) passCount++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    task automatic expectRun(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.pc    = start + 32'(4 * i);
            e.instr = memWord(e.pc);
            expq.push_back(e);
        end
    endtask

    // One clock cycle: memory model decides gnt/rvalid, scoreboard checks a transfer, then the edge.
    task automatic applyStimulus();
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        if (memPend) begin
            if (memCnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = memWord(memAddr);
                memPend     = 1'b0;
                rvalidCount++;
            end else begin
                memCnt--;
            end
        end
        imem_gnt = imem_req && !memPend && !reset;
        lastGnt  = imem_gnt;
        if (imem_gnt) begin
            memPend     = 1'b1;
            memCnt      = memLat - 1;
            memAddr     = imem_addr;
            lastGntAddr = imem_addr;
        end
        if (!reset && !redirect_valid && if_valid && id_ready && expq.size() > 0) begin
            exp_t e;
            e = expq.pop_front();
            checkOutput("if_pc", if_pc, e.pc);
            checkOutput("if_instr", if_instr, e.instr);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic waitDrain(input string tag);
        int n = 0;
        while (expq.size() > 0 && n < 300) begin
            applyStimulus();
            n++;
        end
        checkOutput({tag, "_drained"}, 32'(expq.size()), 32'd0);
        expq.delete();
    endtask

    task automatic resetDut();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        id_ready       = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        int base;
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        id_ready       = 1'b1;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;

        // Reset values and straight-line fetch with 1-cycle memory.
        memLat = 1;
        resetDut();
        checkOutput("rst_if_valid", 32'(if_valid), 32'd0);
        checkOutput("rst_if_instr", if_instr, 32'd0);
        checkOutput("rst_if_pc", if_pc, 32'd0);
        checkOutput("rst_imem_req", 32'(imem_req), 32'd1);
        checkOutput("rst_imem_addr", imem_addr, 32'd0);
        reset = 1'b0;
        expectRun(32'h0, 3);
        n = 0;
        while (!if_valid && n < 20) begin
            applyStimulus();
            n++;
        end
        checkOutput("first_valid_latency", 32'(n), 32'(memLat + 1));
        waitDrain("seq");

        // Decoder stall: outputs hold, buffer absorbs BUF_DEPTH words, no loss after release.
        resetDut();
        base  = rvalidCount;
        reset = 1'b0;
        expectRun(32'h0, 5);
        n = 0;
        while (!if_valid && n < 20) begin
            applyStimulus();
            n++;
        end
        id_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus();
            checkOutput("stall_valid", 32'(if_valid), 32'd1);
            checkOutput("stall_pc", if_pc, 32'h0);
            checkOutput("stall_instr", if_instr, memWord(32'h0));
        end
        checkOutput("stall_depth", 32'(rvalidCount - base), 32'(BUF_DEPTH));
        checkOutput("stall_no_req", 32'(imem_req), 32'd0);
        id_ready = 1'b1;
        waitDrain("stall");

        // Redirect to 0x40 while waiting for the 0x8 response (2-cycle memory).
        memLat = 2;
        resetDut();
        reset = 1'b0;
        expectRun(32'h0, 1);
        waitDrain("pre_redir");
        n = 0;
        while (!(lastGnt && lastGntAddr == 32'h8) && n < 50) begin
            applyStimulus();
            n++;
        end
        checkOutput("wait_gnt8", 32'(lastGnt && lastGntAddr == 32'h8), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        applyStimulus();
        redirect_valid = 1'b0;
        checkOutput("redir_wait_valid", 32'(if_valid), 32'd0);
        checkOutput("redir_wait_req", 32'(imem_req), 32'd0);
        expectRun(32'h40, 3);
        waitDrain("redir_wait");

        // Redirect to 0x43 in the same cycle as a grant: discard, then fetch 0x40.
        memLat = 1;
        n = 0;
        while (!(imem_req && !memPend) && n < 50) begin
            applyStimulus();
            n++;
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h43;
        applyStimulus();
        redirect_valid = 1'b0;
        checkOutput("coinc_gnt_taken", 32'(lastGnt), 32'd1);
        checkOutput("coinc_req_low", 32'(imem_req), 32'd0);
        checkOutput("coinc_addr", imem_addr, 32'h40);
        checkOutput("coinc_valid", 32'(if_valid), 32'd0);
        applyStimulus();
        checkOutput("coinc_refetch_req", 32'(imem_req), 32'd1);
        checkOutput("coinc_refetch_addr", imem_addr, 32'h40);
        expectRun(32'h40, 3);
        waitDrain("coinc");

        // Redirect meeting rvalid in WAIT: data dropped, straight back to FETCH.
        n = 0;
        while (!lastGnt && n < 50) begin
            applyStimulus();
            n++;
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h80;
        applyStimulus();
        redirect_valid = 1'b0;
        checkOutput("redir_rv_req", 32'(imem_req), 32'd1);
        checkOutput("redir_rv_addr", imem_addr, 32'h80);
        checkOutput("redir_rv_valid", 32'(if_valid), 32'd0);
        expectRun(32'h80, 2);
        waitDrain("redir_rv");

        // Address wrap past the top of the address space.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        applyStimulus();
        redirect_valid = 1'b0;
        expectRun(32'hFFFF_FFF8, 4);
        waitDrain("wrap");

        // Reset while waiting; the late response must be ignored.
        memLat = 2;
        n = 0;
        while (!(lastGnt && memCnt == 1) && n < 50) begin
            applyStimulus();
            n++;
        end
        reset = 1'b1;
        applyStimulus();
        reset = 1'b0;
        checkOutput("rst_wait_valid", 32'(if_valid), 32'd0);
        checkOutput("rst_wait_req", 32'(imem_req), 32'd1);
        checkOutput("rst_wait_addr", imem_addr, 32'h0);
        applyStimulus();
        checkOutput("late_rvalid_valid", 32'(if_valid), 32'd0);
        expectRun(32'h0, 3);
        waitDrain("rst_wait");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
